// File: rtl/cpu_core_pkg.sv
// Shared types for the cpu_core_n datapath: opcodes, FSM states and command field offsets.
package cpu_core_pkg;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_SUB   = 4'd2,
    OP_MUL   = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_XOR   = 4'd6,
    OP_SHL   = 4'd7,
    OP_SHR   = 4'd8,
    OP_CMP   = 4'd9,
    OP_STORE = 4'd10,
    OP_LOAD  = 4'd11
  } opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OPER = 2'd1,
    ST_EXEC = 2'd2,
    ST_WB   = 2'd3
  } state_t;

  localparam int OPC_LSB   = 0;
  localparam int OPC_W     = 4;
  localparam int SEL_A_LSB = OPC_LSB + OPC_W;

  // sel_b sits directly above sel_a, so its offset depends on the select width.
  function automatic int sel_b_lsb(input int sel_w);
    return SEL_A_LSB + sel_w;
  endfunction

endpackage

// File: rtl/cpu_core_alu.sv
// Combinational ALU for cpu_core_n: opcodes 0-9 on zero-extended operands, flags opcodes 12-15.
module cpu_core_alu
  import cpu_core_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] result,
  output logic               op_invalid
);

  localparam int RW   = 2 * WIDTH;
  localparam int SH_W = $clog2(RW);

  logic [RW-1:0]   a_x;
  logic [RW-1:0]   b_x;
  logic [SH_W-1:0] sh;

  assign a_x = {{WIDTH{1'b0}}, a};
  assign b_x = {{WIDTH{1'b0}}, b};
  assign sh  = b[SH_W-1:0];

  // NOP/STORE/LOAD produce no ALU value; the top selects the held result or memory data.
  always_comb begin
    result     = '0;
    op_invalid = 1'b0;
    case (op)
      OP_ADD:  result = a_x + b_x;
      OP_SUB:  result = a_x - b_x;
      OP_MUL:  result = a_x * b_x;
      OP_AND:  result = a_x & b_x;
      OP_OR:   result = a_x | b_x;
      OP_XOR:  result = a_x ^ b_x;
      OP_SHL:  result = a_x << sh;
      OP_SHR:  result = a_x >> sh;
      OP_CMP:  result = {{(RW-1){1'b0}}, (a > b)};
      OP_NOP, OP_STORE, OP_LOAD: result = '0;
      default: op_invalid = 1'b1;
    endcase
  end

endmodule

// File: rtl/cpu_core_n.sv
// Parametrised CPU datapath core: command handshake, operand muxes, ALU, scratch memory, result/flags.
// Optional executed-command counter enabled by defining CPU_CORE_PERF_CNT_EN.
//
// state   | meaning
// --------+---------------------------------------------------------
// ST_IDLE | cmd_ready high, waiting for cmd_valid; command latched
// ST_OPER | operands and memory address latched from muxes/inputs
// ST_EXEC | ALU evaluated, STORE writes memory, LOAD reads memory
// ST_WB   | result and flags registered, res_valid strobed next cycle
module cpu_core_n
  import cpu_core_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int NUM_IN    = 3,
  parameter  int MEM_DEPTH = 16,
  localparam int ADDR_W    = $clog2(MEM_DEPTH),
  localparam int SEL_W     = $clog2(NUM_IN + 1),
  localparam int CMD_W     = 4 + 2 * SEL_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [CMD_W-1:0]        cmd_in,
  input  logic [NUM_IN*WIDTH-1:0] din,
  input  logic [ADDR_W-1:0]       mem_addr,
  output logic [WIDTH-1:0]        dout_low,
  output logic [WIDTH-1:0]        dout_high,
  output logic                    res_valid,
  output logic                    zero,
  output logic                    error,
  output logic [15:0]             perf_count
);

  localparam int RW        = 2 * WIDTH;
  localparam int SEL_B_LSB = sel_b_lsb(SEL_W);
  localparam logic [SEL_W-1:0] FB_SEL = SEL_W'(NUM_IN);

  state_t              state;
  logic [CMD_W-1:0]    cmd_q;
  logic [WIDTH-1:0]    op_a, op_b;
  logic [WIDTH-1:0]    mux_a, mux_b;
  logic [ADDR_W-1:0]   addr_q;
  logic [RW-1:0]       mem [MEM_DEPTH];
  logic [RW-1:0]       rd_q;
  logic [RW-1:0]       alu_res;
  logic [RW-1:0]       exec_res;
  logic [RW-1:0]       wb_res;
  logic [RW-1:0]       cur_res;
  logic                exec_err, exec_load;
  logic                alu_inv, sel_bad, cmd_err;
  logic [3:0]          opc;
  logic [SEL_W-1:0]    sel_a, sel_b;

  assign opc     = cmd_q[OPC_LSB +: OPC_W];
  assign sel_a   = cmd_q[SEL_A_LSB +: SEL_W];
  assign sel_b   = cmd_q[SEL_B_LSB +: SEL_W];
  assign cur_res = {dout_high, dout_low};
  assign sel_bad = (sel_a > FB_SEL) || (sel_b > FB_SEL);
  assign cmd_err = alu_inv || ((opc != OP_NOP) && sel_bad);
  assign wb_res  = exec_err ? '0 : (exec_load ? rd_q : exec_res);

  // Feedback select routes the high half to A and the low half to B.
  always_comb begin
    mux_a = '0;
    mux_b = '0;
    for (int i = 0; i < NUM_IN; i++) begin
      if (sel_a == SEL_W'(i)) mux_a = din[i*WIDTH +: WIDTH];
      if (sel_b == SEL_W'(i)) mux_b = din[i*WIDTH +: WIDTH];
    end
    if (sel_a == FB_SEL) mux_a = dout_high;
    if (sel_b == FB_SEL) mux_b = dout_low;
  end

  cpu_core_alu #(.WIDTH(WIDTH)) u_alu (
    .op         (opc),
    .a          (op_a),
    .b          (op_b),
    .result     (alu_res),
    .op_invalid (alu_inv)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cmd_ready <= 1'b1;
      cmd_q     <= '0;
      op_a      <= '0;
      op_b      <= '0;
      addr_q    <= '0;
      exec_res  <= '0;
      exec_err  <= 1'b0;
      exec_load <= 1'b0;
      dout_low  <= '0;
      dout_high <= '0;
      res_valid <= 1'b0;
      zero      <= 1'b0;
      error     <= 1'b0;
    end else begin
      res_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_q     <= cmd_in;
            cmd_ready <= 1'b0;
            state     <= ST_OPER;
          end
        end
        ST_OPER: begin
          op_a   <= mux_a;
          op_b   <= mux_b;
          addr_q <= mem_addr;
          state  <= ST_EXEC;
        end
        ST_EXEC: begin
          exec_err  <= cmd_err;
          exec_load <= (opc == OP_LOAD);
          exec_res  <= ((opc == OP_NOP) || (opc == OP_STORE)) ? cur_res : alu_res;
          state     <= ST_WB;
        end
        ST_WB: begin
          dout_low  <= wb_res[WIDTH-1:0];
          dout_high <= wb_res[RW-1:WIDTH];
          zero      <= !exec_err && (wb_res == '0);
          error     <= exec_err;
          res_valid <= 1'b1;
          cmd_ready <= 1'b1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Memory is not reset; an async reset forces ST_IDLE so an aborted STORE never lands.
  always_ff @(posedge clk) begin
    if (state == ST_EXEC) begin
      if ((opc == OP_STORE) && !cmd_err) mem[addr_q] <= cur_res;
      else if (opc == OP_LOAD)           rd_q <= mem[addr_q];
    end
  end

`ifdef CPU_CORE_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                perf_count <= '0;
    else if (state == ST_WB) perf_count <= perf_count + 16'd1;
  end
`else
  assign perf_count = '0;
`endif

endmodule
